// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filter, frame checks, watchdog and show-ahead FIFO.
// Optional make/break prefix decoding is enabled by defining PS2_RX_BREAK_DECODE_EN.
module ps2_rx_fifo #(
  parameter int DEPTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     nextdata_n,
  input  logic                     clr_err,
  output logic [9:0]               data,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     parity_err,
  output logic                     frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t         st;
  logic [1:0]     ck_s, dt_s;
  logic           filt, stb, sbit, par;
  logic [FW-1:0]  fcnt;
  logic [TW-1:0]  wd;
  logic [2:0]     bcnt;
  logic [7:0]     shreg;
  logic [9:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           at_stop, good, bad_par, bad_stop, tmo, push, pop, wr_ok, ovf_set;
  logic [9:0]     wdata;

  assign at_stop  = stb && st == STOP;
  assign good     = at_stop && sbit && ^{shreg, par};
  assign bad_par  = at_stop && !(^{shreg, par});
  assign bad_stop = at_stop && !sbit;
  assign tmo      = st != IDLE && !stb && wd == TMAX;
  assign pop      = !nextdata_n && level != '0;
  assign wr_ok    = push && (level != FULL || pop);
  assign ovf_set  = push && level == FULL && !pop;
  assign data     = mem[rd_ptr];
  assign ready    = level != '0;

`ifdef PS2_RX_BREAK_DECODE_EN
  logic ext, brk, is_pfx;
  assign is_pfx = shreg == 8'hE0 || shreg == 8'hF0;
  assign push   = good && !is_pfx;
  assign wdata  = {ext, brk, shreg};
  // Prefix bytes arm the pending flags; the next good code byte or any error consumes them.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (good) begin
      ext <= shreg == 8'hE0 ? 1'b1 : shreg == 8'hF0 ? ext : 1'b0;
      brk <= shreg == 8'hF0 ? 1'b1 : shreg == 8'hE0 ? brk : 1'b0;
    end else if (bad_par || bad_stop || tmo) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end
`else
  assign push  = good;
  assign wdata = {2'b00, shreg};
`endif

  // Synchronise both lines, debounce the clock and emit a strobe on each filtered falling edge.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      ck_s <= 2'b11;
      dt_s <= 2'b11;
      filt <= 1'b1;
      fcnt <= '0;
      stb  <= 1'b0;
      sbit <= 1'b1;
    end else begin
      ck_s <= {ck_s[0], ps2_clk};
      dt_s <= {dt_s[0], ps2_data};
      stb  <= 1'b0;
      if (ck_s[1] == filt) fcnt <= '0;
      else if (fcnt == FMAX) begin
        filt <= ck_s[1];
        fcnt <= '0;
        stb  <= !ck_s[1];
        sbit <= dt_s[1];
      end else fcnt <= fcnt + 1'b1;
    end

  // Frame deserialiser with a watchdog that abandons a stalled frame.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      st    <= IDLE;
      bcnt  <= '0;
      shreg <= '0;
      par   <= 1'b0;
      wd    <= '0;
    end else if (stb) begin
      wd <= '0;
      case (st)
        IDLE: if (!sbit) begin
          st   <= DATA;
          bcnt <= '0;
        end
        DATA: begin
          shreg <= {sbit, shreg[7:1]};
          bcnt  <= bcnt + 1'b1;
          if (bcnt == 3'd7) st <= PARITY;
        end
        PARITY: begin
          par <= sbit;
          st  <= STOP;
        end
        STOP: st <= IDLE;
      endcase
    end else if (tmo) begin
      st <= IDLE;
      wd <= '0;
    end else if (st != IDLE) wd <= wd + 1'b1;

  // FIFO storage, occupancy and sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level      <= level + LW'(wr_ok) - LW'(pop);
      overflow   <= ovf_set || (overflow && !clr_err);
      parity_err <= bad_par || (parity_err && !clr_err);
      frame_err  <= bad_stop || tmo || (frame_err && !clr_err);
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: self-checking bench for ps2_rx_fifo (covers PS2_RX_BREAK_DECODE_EN when defined).
module tb_ps2_rx_fifo;
  localparam int DEPTH = 4;
  localparam int FL    = 4;
  localparam int TO    = 200;

  logic       clk = 1'b0, clrn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, nextdata_n = 1'b1, clr_err = 1'b0;
  logic [9:0] data;
  logic       ready, overflow, parity_err, frame_err;
  logic [2:0] level;
  int         n_tests = 0, n_fail = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    bit         pflip;
    bit         stop;
    int         exp_lvl;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;
  vec_t vt[6];

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .clr_err(clr_err), .data(data), .ready(ready),
    .level(level), .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit pflip, input bit stop);
    return {stop, (~^b) ^ pflip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(10);
      ps2_clk = 1'b0;
      tick(10);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit pflip = 1'b0, input bit stop = 1'b1);
    send_bits(mk(b, pflip, stop), 11);
    tick(20);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic pop_chk();
    logic [9:0] e;
    e = exp_q.pop_front();
    chk("pop_ready", ready, 1);
    chk("pop_data", data, e);
    nextdata_n = 1'b0;
    tick();
    nextdata_n = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 4 * DEPTH) begin
      pop_chk();
      g++;
    end
    chk("drain_level", level, 0);
    chk("drain_ready", ready, 0);
  endtask

  // Send a frame and pop the head in exactly the cycle the new byte is written.
  task automatic send_pop(input logic [7:0] b);
    logic [9:0] e;
    send_bits(mk(b, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    tick(10);
    ps2_clk = 1'b0;
    tick(FL + 2);
    e = exp_q.pop_front();
    chk("sp_head", data, e);
    nextdata_n = 1'b0;
    tick();
    nextdata_n = 1'b1;
    exp_q.push_back({2'b00, b});
    tick(3);
    ps2_clk = 1'b1;
    tick(20);
  endtask

  initial begin
    int n;
    vt[0] = '{8'h1C, 1'b1, 1'b1, 0, 1'b1, 1'b0};
    vt[1] = '{8'h5A, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vt[2] = '{8'h33, 1'b1, 1'b0, 0, 1'b1, 1'b1};
    vt[3] = '{8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    vt[5] = '{8'hE1, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    tick(3);
    chk("rst_ready", ready, 0);
    chk("rst_level", level, 0);
    chk("rst_data", data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pe", parity_err, 0);
    chk("rst_fe", frame_err, 0);
    clrn = 1'b1;
    tick(2);
    // Stop-bit strobe to ready latency: 2 sync + FILTER_LEN to strobe, +1 for the write.
    send_bits(mk(8'h1C, 1'b0, 1'b1), 10);
    tick(10);
    ps2_clk = 1'b0;
    n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    chk("first_latency", n, FL + 3);
    chk("first_data", data, 10'h01C);
    chk("first_level", level, 1);
    tick(5);
    ps2_clk = 1'b1;
    tick(20);
    nextdata_n = 1'b0;
    tick();
    nextdata_n = 1'b1;
    chk("first_pop_ready", ready, 0);
    chk("first_pop_level", level, 0);
    for (int i = 0; i < 6; i++) begin
      send(vt[i].b, vt[i].pflip, vt[i].stop);
      chk("vec_level", level, vt[i].exp_lvl);
      chk("vec_pe", parity_err, vt[i].exp_pe);
      chk("vec_fe", frame_err, vt[i].exp_fe);
      if (vt[i].exp_lvl != 0) exp_q.push_back({2'b00, vt[i].b});
      drain();
      pulse_clr();
      chk("vec_clr_pe", parity_err, 0);
      chk("vec_clr_fe", frame_err, 0);
    end
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send(8'(i));
      if (i <= DEPTH) exp_q.push_back(10'(i));
    end
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    drain();
    pulse_clr();
    chk("ovf_clr", overflow, 0);
    send_bits(mk(8'h5A, 1'b0, 1'b1), 6);
    chk("wd_before", frame_err, 0);
    tick(TO + 20);
    chk("wd_fe", frame_err, 1);
    chk("wd_level", level, 0);
    pulse_clr();
    send(8'h29);
    exp_q.push_back(10'h029);
    chk("wd_next_level", level, 1);
    chk("wd_next_fe", frame_err, 0);
    drain();
    for (int i = 0; i < DEPTH; i++) begin
      send(8'h40 + 8'(i));
      exp_q.push_back({2'b00, 8'h40 + 8'(i)});
    end
    for (int i = 0; i < 2; i++) begin
      send_pop(8'h50 + 8'(i));
      chk("full_sp_level", level, DEPTH);
      chk("full_sp_ovf", overflow, 0);
    end
    drain();
    send(8'h61);
    exp_q.push_back(10'h061);
    send_pop(8'h62);
    chk("one_sp_level", level, 1);
    chk("one_sp_ready", ready, 1);
    drain();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
`ifdef PS2_RX_BREAK_DECODE_EN
    exp_q.push_back(10'h375);
`else
    exp_q.push_back(10'h0E0);
    exp_q.push_back(10'h0F0);
    exp_q.push_back(10'h075);
`endif
    chk("dec1_level", level, exp_q.size());
    drain();
    send(8'hF0);
    send(8'h1C);
`ifdef PS2_RX_BREAK_DECODE_EN
    exp_q.push_back(10'h11C);
`else
    exp_q.push_back(10'h0F0);
    exp_q.push_back(10'h01C);
`endif
    chk("dec2_level", level, exp_q.size());
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
